mem_stage: RTL and testbench

- MEM stage of the 5-stage RISC-V pipeline; consumes the EX/MEM pipeline register outputs.
- Drives a multi-cycle data-memory req/ack interface and freezes the upstream pipeline while an access is outstanding.
- Contains the MEM/WB boundary register: all WB-bound outputs are registered and feed the writeback mux directly.
- Includes a saturating stall-cycle counter for performance debug.

---
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage: multi-cycle data-memory access, upstream freeze and MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALUres_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [4:0]        RegisterRd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic [DATA_W-1:0] ALUres_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [4:0]        RegisterRd_o,
    output logic [CNT_W-1:0]  stall_cycles_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic              mem_op;
    logic              issue;
    logic              misal;

    logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
    logic              we_q, rw_q, mtr_q;
    logic [4:0]        rd_q;

    logic              wb_rw_q, wb_rw_d;
    logic              wb_mtr_q, wb_mtr_d;
    logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
    logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
    logic [4:0]        wb_rd_q, wb_rd_d;

    logic [CNT_W-1:0]  cnt_q;

    assign mem_op = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign misal = mem_op & (ALUres_i[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign issue = mem_op & ~misal;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue) state_d = REQ;
            REQ:     if (mem_ack_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory interface and stall outputs
    always_comb begin
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            IDLE: stall_o = issue;
            REQ: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
            end
            default: ;
        endcase
        if (!rst_i) stall_o = 1'b0;
    end

    // Hold registers capture the access and its read data
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            rw_q    <= 1'b0;
            mtr_q   <= 1'b0;
            rd_q    <= '0;
        end else if (state_q == IDLE && issue) begin
            addr_q  <= ALUres_i;
            wdata_q <= RS2data_i;
            we_q    <= MemWrite_i;
            rw_q    <= RegWrite_i;
            mtr_q   <= MemToReg_i;
            rd_q    <= RegisterRd_i;
        end else if (state_q == REQ && mem_ack_i) begin
            rdata_q <= we_q ? '0 : mem_rdata_i;
        end
    end

    // MEM/WB next value: bubble, completed access, or pass-through
    always_comb begin
        wb_rw_d    = wb_rw_q;
        wb_mtr_d   = wb_mtr_q;
        wb_alu_d   = wb_alu_q;
        wb_rdata_d = wb_rdata_q;
        wb_rd_d    = wb_rd_q;
        if (stall_o || (state_q == IDLE && mem_op)) begin
            wb_rw_d  = 1'b0;
            wb_mtr_d = 1'b0;
            wb_rd_d  = '0;
        end else if (state_q == DONE) begin
            wb_rw_d    = rw_q;
            wb_mtr_d   = mtr_q;
            wb_alu_d   = addr_q;
            wb_rdata_d = rdata_q;
            wb_rd_d    = rd_q;
        end else begin
            wb_rw_d    = RegWrite_i;
            wb_mtr_d   = MemToReg_i;
            wb_alu_d   = ALUres_i;
            wb_rdata_d = '0;
            wb_rd_d    = RegisterRd_i;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wb_rw_q    <= 1'b0;
            wb_mtr_q   <= 1'b0;
            wb_alu_q   <= '0;
            wb_rdata_q <= '0;
            wb_rd_q    <= '0;
        end else begin
            wb_rw_q    <= wb_rw_d;
            wb_mtr_q   <= wb_mtr_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign RegWrite_o   = wb_rw_q;
    assign MemToReg_o   = wb_mtr_q;
    assign ALUres_o     = wb_alu_q;
    assign ReadData_o   = wb_rdata_q;
    assign RegisterRd_o = wb_rd_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clk_i) begin
        if (!rst_i)                      cnt_q <= '0;
        else if (stall_o && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign stall_cycles_o = cnt_q;

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;

    // Misalign flag pulses alongside the bubble it causes
    always_ff @(posedge clk_i) begin
        if (!rst_i) mis_q <= 1'b0;
        else        mis_q <= (state_q == IDLE) & misal;
    end

    assign misalign_o = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random ops against a transaction model.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        RegWrite_i = 1'b0, MemToReg_i = 1'b0;
    logic        MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [31:0] ALUres_i = '0, RS2data_i = '0;
    logic [4:0]  RegisterRd_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    logic        req, we, stall, rw_o, mtr_o;
    logic [31:0] addr, wdata, alu_o, rdata_o;
    logic [4:0]  rd_o;
    logic [15:0] cnt;

    logic        s_req, s_we, s_stall, s_rw, s_mtr;
    logic [31:0] s_addr, s_wdata, s_alu, s_rdata;
    logic [4:0]  s_rd;
    logic [1:0]  s_cnt;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mis_o, s_mis;
`endif

    int n_chk = 0;
    int n_err = 0;

    bit          m_rw, m_mtr, m_mis;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdata;
    int          m_cnt;

    always #5 clk = ~clk;

    mem_stage u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .ALUres_i(ALUres_i), .RS2data_i(RS2data_i),
        .RegisterRd_i(RegisterRd_i),
        .mem_req_o(req), .mem_we_o(we),
        .mem_addr_o(addr), .mem_wdata_o(wdata),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall), .RegWrite_o(rw_o), .MemToReg_o(mtr_o),
        .ALUres_o(alu_o), .ReadData_o(rdata_o),
        .RegisterRd_o(rd_o), .stall_cycles_o(cnt)
`ifdef MEM_ALIGN_CHECK_EN
        , .misalign_o(mis_o)
`endif
    );

    mem_stage #(.CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst_i),
        .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .ALUres_i(ALUres_i), .RS2data_i(RS2data_i),
        .RegisterRd_i(RegisterRd_i),
        .mem_req_o(s_req), .mem_we_o(s_we),
        .mem_addr_o(s_addr), .mem_wdata_o(s_wdata),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(s_stall), .RegWrite_o(s_rw), .MemToReg_o(s_mtr),
        .ALUres_o(s_alu), .ReadData_o(s_rdata),
        .RegisterRd_o(s_rd), .stall_cycles_o(s_cnt)
`ifdef MEM_ALIGN_CHECK_EN
        , .misalign_o(s_mis)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_wb();
        check("RegWrite_o", rw_o, m_rw);
        check("MemToReg_o", mtr_o, m_mtr);
        check("ALUres_o", alu_o, m_alu);
        check("ReadData_o", rdata_o, m_rdata);
        check("RegisterRd_o", rd_o, m_rd);
        check("stall_cycles", cnt, (m_cnt > 65535) ? 65535 : m_cnt);
        check("stall_cycles_sat", s_cnt, (m_cnt > 3) ? 3 : m_cnt);
`ifdef MEM_ALIGN_CHECK_EN
        check("misalign_o", mis_o, m_mis);
`endif
    endtask

    task automatic model_clear();
        m_rw = 0; m_mtr = 0; m_mis = 0;
        m_rd = '0; m_alu = '0; m_rdata = '0; m_cnt = 0;
    endtask

    task automatic nop_inputs();
        RegWrite_i = 0; MemToReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
        ALUres_i = '0; RS2data_i = '0; RegisterRd_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        nop_inputs();
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("rst_stall", stall, 0);
        @(posedge clk); #1;
        model_clear();
        @(negedge clk);
        check_wb();
        check("rst_req", req, 0);
        check("rst_addr", addr, 0);
        @(posedge clk); #1;
        rst_i = 1'b1;
    endtask

    // One instruction held on the EX/MEM inputs until the stage accepts it;
    // k is the REQ cycle on which memory acks, spur adds stray acks
    task automatic do_op(input bit rw, input bit mtr, input logic [4:0] rd,
                         input bit mr, input bit mw,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rdv, input int k, input bit spur);
        bit mem, mis;
        logic [31:0] al;
        mem = mr | mw;
        al  = a;
`ifdef MEM_ALIGN_CHECK_EN
        mis = mem && (al[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        RegWrite_i = rw; MemToReg_i = mtr; RegisterRd_i = rd;
        MemRead_i = mr; MemWrite_i = mw; ALUres_i = a; RS2data_i = d;
        mem_ack_i = 1'b0;
        if (!mem || mis) begin
            mem_ack_i = spur;
            @(negedge clk);
            check_wb();
            check("stall_idle", stall, 0);
            check("req_idle", req, 0);
            if (mis) begin
                m_rw = 0; m_mtr = 0; m_rd = '0; m_mis = 1;
            end else begin
                m_rw = rw; m_mtr = mtr; m_rd = rd;
                m_alu = a; m_rdata = '0; m_mis = 0;
            end
            @(posedge clk); #1;
        end else begin
            for (int c = 0; c <= k + 1; c++) begin
                bit r;
                mem_ack_i   = (c == k) || (spur && (c == 0 || c == k + 1));
                mem_rdata_i = (c == k) ? rdv : $urandom;
                r = (c >= 1) && (c <= k);
                @(negedge clk);
                check_wb();
                check("stall", stall, (c <= k));
                check("mem_req", req, r);
                check("mem_we", we, r ? mw : 1'b0);
                check("mem_addr", addr, r ? a : 32'h0);
                check("mem_wdata", wdata, r ? d : 32'h0);
                m_mis = 0;
                if (c <= k) begin
                    m_rw = 0; m_mtr = 0; m_rd = '0;
                    m_cnt++;
                end else begin
                    m_rw = rw; m_mtr = mtr; m_rd = rd; m_alu = a;
                    m_rdata = mw ? 32'h0 : rdv;
                end
                @(posedge clk); #1;
            end
        end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        model_clear();
        @(posedge clk); #1;
        do_reset();

        do_op(1, 0, 5'd5, 0, 0, 32'h0000_00AA, 32'h0, 32'h0, 0, 0);
        do_op(1, 1, 5'd7, 1, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 0);
        do_op(0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        do_op(0, 0, 5'd3, 0, 1, 32'h0000_0200, 32'h1234, 32'hFFFF_FFFF, 1, 1);
        do_op(1, 1, 5'd9, 1, 1, 32'h0000_0204, 32'h5A5A, 32'h7777_7777, 2, 0);
`ifdef MEM_ALIGN_CHECK_EN
        do_op(1, 1, 5'd4, 1, 0, 32'h0000_0102, 32'h0, 32'h0, 1, 0);
`endif
        do_op(1, 0, 5'd1, 0, 0, 32'h1111_0000, 32'h0, 32'h0, 0, 0);

        // Reset lands while a load is waiting on memory; its ack arrives late
        RegWrite_i = 1; MemToReg_i = 1; RegisterRd_i = 5'd6;
        MemRead_i = 1; MemWrite_i = 0; ALUres_i = 32'h300; RS2data_i = '0;
        @(negedge clk);
        check_wb();
        check("midreq_stall0", stall, 1);
        m_rw = 0; m_mtr = 0; m_rd = '0; m_mis = 0; m_cnt++;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("midreq_req", req, 1);
        check("midreq_rst_stall", stall, 0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        nop_inputs();
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        model_clear();
        @(negedge clk);
        check_wb();
        check("late_ack_req", req, 0);
        check("late_ack_stall", stall, 0);
        check("late_ack_we", we, 0);
        check("late_ack_addr", addr, 0);
        check("late_ack_wdata", wdata, 0);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        do_op(1, 0, 5'd12, 0, 0, 32'h0000_0ABC, 32'h0, 32'h0, 0, 0);

        // Three back-to-back minimum-latency loads saturate the 2-bit counter
        do_reset();
        do_op(1, 1, 5'd2, 1, 0, 32'h10, 32'h0, 32'h1, 1, 0);
        do_op(1, 1, 5'd3, 1, 0, 32'h14, 32'h0, 32'h2, 1, 0);
        do_op(1, 1, 5'd4, 1, 0, 32'h18, 32'h0, 32'h3, 1, 0);
        do_op(0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            bit mr, mw, rw, mtr, sp;
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 3);
            rw   = $urandom_range(0, 1);
            mtr  = $urandom_range(0, 1);
            sp   = $urandom_range(0, 1);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            mr = 0; mw = 0;
            if (kind != 0) begin
                mr = $urandom_range(0, 1);
                mw = !mr || ($urandom_range(0, 3) == 0);
            end
            do_op(rw, mtr, 5'($urandom), mr, mw, a, $urandom, $urandom,
                  $urandom_range(1, 5), sp);
        end
        do_op(0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
